link_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 4-phase req/ack byte link (downstream slave FSM) between
//  N_REQ upstream masters. Grants one master at a time and relays its req/data downstream.

---
 rtl/link_arbiter_pkg.sv | 16 +
 rtl/link_arbiter_if.sv | 31 +++
 rtl/link_arbiter_rr_pick.sv | 31 +++
 rtl/link_arbiter.sv | 119 +++++++++++
 tb/tb_link_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/link_arbiter_pkg.sv
// Shared types and defaults for the 4-phase byte link: arbiter state encoding
// plus the widths the master/slave FSMs and the arbiter agree on.
package link_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACKM = 2'd2,
      REL  = 2'd3
   } arb_state_e;

   localparam int LINK_N_REQ  = 4;
   localparam int LINK_DATA_W = 8;
   localparam int LINK_CNT_W  = 16;

endpackage

// File: rtl/link_arbiter_if.sv
// Bundle of the upstream master links, the single downstream slave link and arbiter status.
// The arbiter drives the downstream link, so it connects through the master modport.
interface link_arbiter_if
   import link_arbiter_pkg::*;
#(
   parameter int N_REQ = LINK_N_REQ,
   parameter int DW    = LINK_DATA_W,
   parameter int CNT_W = LINK_CNT_W
);

   logic [N_REQ-1:0]          req_i;
   logic [N_REQ-1:0][DW-1:0]  data_i;
   logic [N_REQ-1:0]          ack_o;
   logic                      req_o;
   logic [DW-1:0]             data_o;
   logic                      ack_i;
   logic [N_REQ-1:0]          grant_o;
   logic                      busy;
   logic [CNT_W-1:0]          xfer_count;

   modport master (
      input  req_i, data_i, ack_i,
      output ack_o, req_o, data_o, grant_o, busy, xfer_count
   );

   modport slave (
      output req_i, data_i, ack_i,
      input  ack_o, req_o, data_o, grant_o, busy, xfer_count
   );

endinterface

// File: rtl/link_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module link_arbiter_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   int j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= N_REQ) j = j - N_REQ;
         if (!any && req[j]) begin
            any      = 1'b1;
            idx      = IDX_W'(j);
            grant[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/link_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack byte link among N_REQ masters.
// Only the granted master sees the slave's ack; the others wait for the full handshake.
module link_arbiter
   import link_arbiter_pkg::*;
#(
   parameter int N_REQ = LINK_N_REQ,
   parameter int DW    = LINK_DATA_W,
   parameter int CNT_W = LINK_CNT_W
) (
   input  logic           clk,
   input  logic           rst,
   link_arbiter_if.master bus
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  gidx_q, gidx_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic              req_q, req_d;
   logic [DW-1:0]     data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;

   logic [N_REQ-1:0]  pick_grant;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;

   link_arbiter_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req   (bus.req_i),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      grant_d = grant_q;
      ack_d   = ack_q;
      req_d   = req_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = REQ;
               grant_d = pick_grant;
               gidx_d  = pick_idx;
               data_d  = bus.data_i[pick_idx];
               req_d   = 1'b1;
            end
         end
         REQ: begin
            if (bus.ack_i) begin
               ack_d   = grant_q;
               state_d = ACKM;
            end
         end
         // A master that dropped req early falls straight through here.
         ACKM: begin
            if (!bus.req_i[gidx_q]) begin
               req_d   = 1'b0;
               state_d = REL;
            end
         end
         REL: begin
            if (!bus.ack_i) begin
               ack_d   = '0;
               grant_d = '0;
               ptr_d   = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
               cnt_d   = cnt_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         req_q   <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         req_q   <= req_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.ack_o      = ack_q;
   assign bus.req_o      = req_q;
   assign bus.data_o     = data_q;
   assign bus.grant_o    = grant_q;
   assign bus.busy       = busy_q;
   assign bus.xfer_count = cnt_q;

endmodule

// File: tb/tb_link_arbiter.sv
// Bench for link_arbiter: behavioural master/slave agents, a transaction-level
// reference model checked every cycle, and directed scenarios with fixed expectations.
module tb_link_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   link_arbiter_if #(.N_REQ(NR), .DW(DW), .CNT_W(CW)) bus ();

   link_arbiter #(.N_REQ(NR), .DW(DW), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: who owns the link and which handshake phases have happened
   int            m_owner, m_ptr, m_cnt;
   bit            m_acked, m_rel, m_reqo;
   logic [DW-1:0] m_data;

   // agent controls
   int            m_left  [NR];
   bit            m_drop  [NR];
   bit            m_scram [NR];
   logic [DW-1:0] m_byte  [NR];
   bit            rnd_data;
   int            sl_wait, sl_lat;

   logic [DW-1:0] rxq[$];
   logic [NR-1:0] gq[$];
   bit            ack_seen [NR];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_winner(input int ptr, input logic [NR-1:0] r);
      for (int k = 0; k < NR; k++)
         if (r[(ptr + k) % NR]) return (ptr + k) % NR;
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_cnt = 0;
      m_acked = 0;  m_rel = 0; m_reqo = 0; m_data = '0;
   endtask

   task automatic model_edge(input bit r, input logic [NR-1:0] rq,
                             input logic [NR-1:0][DW-1:0] d, input logic a);
      int w;
      if (r) model_reset();
      else if (m_owner < 0) begin
         w = rr_winner(m_ptr, rq);
         if (w >= 0) begin
            m_owner = w; m_data = d[w]; m_reqo = 1; m_acked = 0; m_rel = 0;
         end
      end else if (!m_acked) begin
         if (a) m_acked = 1;
      end else if (!m_rel) begin
         if (!rq[m_owner]) begin m_rel = 1; m_reqo = 0; end
      end else if (!a) begin
         m_ptr   = (m_owner + 1) % NR;
         m_cnt   = (m_cnt + 1) % (1 << CW);
         m_owner = -1; m_acked = 0; m_rel = 0;
      end
   endtask

   task automatic check_outputs();
      logic [NR-1:0] eg, ea;
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      ea = m_acked ? eg : '0;
      chk("grant_o",    bus.grant_o,    eg);
      chk("ack_o",      bus.ack_o,      ea);
      chk("req_o",      bus.req_o,      m_reqo);
      chk("data_o",     bus.data_o,     m_data);
      chk("busy",       bus.busy,       m_owner >= 0);
      chk("xfer_count", bus.xfer_count, m_cnt);
   endtask

   task automatic drive(input bit r);
      for (int m = 0; m < NR; m++) begin
         if (bus.req_i[m]) begin
            if (bus.ack_o[m]) bus.req_i[m] = 1'b0;
            else if (m_drop[m] && bus.grant_o[m] && bus.req_o) begin
               bus.req_i[m] = 1'b0;
               m_drop[m]    = 0;
            end else if (m_scram[m] && bus.grant_o[m])
               bus.data_i[m] = DW'($urandom);
         end else if (!bus.ack_o[m] && m_left[m] > 0) begin
            bus.req_i[m]  = 1'b1;
            bus.data_i[m] = rnd_data ? DW'($urandom) : m_byte[m];
            m_left[m]--;
         end
      end
      if (r) begin
         bus.ack_i = 1'b0;
         sl_wait   = 0;
      end else if (bus.req_o && !bus.ack_i) begin
         if (sl_wait == 0) begin
            bus.ack_i = 1'b1;
            rxq.push_back(bus.data_o);
            sl_wait = $urandom_range(sl_lat, 0);
         end else sl_wait--;
      end else if (!bus.req_o && bus.ack_i) begin
         if (sl_wait == 0) begin
            bus.ack_i = 1'b0;
            sl_wait = $urandom_range(sl_lat, 0);
         end else sl_wait--;
      end
   endtask

   task automatic step();
      bit                       r;
      logic [NR-1:0]            rq, pg;
      logic [NR-1:0][DW-1:0]    d;
      logic                     a;
      r = rst; rq = bus.req_i; d = bus.data_i; a = bus.ack_i; pg = bus.grant_o;
      @(posedge clk);
      model_edge(r, rq, d, a);
      #1;
      check_outputs();
      if (pg == '0 && bus.grant_o != '0) gq.push_back(bus.grant_o);
      for (int m = 0; m < NR; m++)
         if (bus.ack_o[m]) ack_seen[m] = 1;
      drive(r);
   endtask

   function automatic bit idle_all();
      for (int m = 0; m < NR; m++)
         if (m_left[m] != 0) return 0;
      return bus.req_i == '0 && !bus.ack_i && m_owner < 0;
   endfunction

   task automatic wait_done(input int budget, input string tag);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         step();
         ok = idle_all();
      end
      chk({tag, "_done"}, ok, 1);
   endtask

   task automatic clear_logs();
      rxq.delete();
      gq.delete();
      for (int m = 0; m < NR; m++) ack_seen[m] = 0;
   endtask

   initial begin
      bus.req_i  = '0;
      bus.data_i = '0;
      bus.ack_i  = 1'b0;
      for (int m = 0; m < NR; m++) begin
         m_left[m] = 0; m_drop[m] = 0; m_scram[m] = 0; m_byte[m] = '0; ack_seen[m] = 0;
      end
      rnd_data = 0; sl_lat = 2; sl_wait = 0;
      model_reset();

      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      chk("rst_grant", bus.grant_o, 0);
      chk("rst_busy",  bus.busy,    0);
      chk("rst_count", bus.xfer_count, 0);

      // reset in the middle of REQ with req_o asserted
      sl_wait = 100; m_byte[0] = 8'hA5; m_left[0] = 1;
      for (int i = 0; i < 6 && !bus.req_o; i++) step();
      chk("t1_req_before_rst", bus.req_o, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.req_i = '0;
      sl_wait = 0;
      chk("t1_req_o",  bus.req_o,      0);
      chk("t1_data_o", bus.data_o,     0);
      chk("t1_grant",  bus.grant_o,    0);
      chk("t1_ack",    bus.ack_o,      0);
      chk("t1_busy",   bus.busy,       0);
      chk("t1_count",  bus.xfer_count, 0);

      // single master, slave answers two cycles late
      clear_logs();
      sl_wait = 2; m_byte[0] = 8'hA5; m_left[0] = 1;
      step(); step();
      chk("t2_req_o",  bus.req_o,   1);
      chk("t2_data_o", bus.data_o,  8'hA5);
      chk("t2_grant",  bus.grant_o, 4'b0001);
      wait_done(60, "t2");
      chk("t2_rx_n",   rxq.size(),  1);
      if (rxq.size() > 0) chk("t2_rx", rxq[0], 8'hA5);
      chk("t2_ackseen", ack_seen[0], 1);
      chk("t2_count",  bus.xfer_count, 1);
      chk("t2_grant0", bus.grant_o, 0);

      // all four contend from a fresh pointer
      rst = 1'b1; step(); rst = 1'b0;
      clear_logs();
      for (int m = 0; m < NR; m++) begin m_byte[m] = 8'h10 + DW'(m); m_left[m] = 1; end
      wait_done(300, "t3");
      chk("t3_rx_n", rxq.size(), 4);
      chk("t3_g_n",  gq.size(),  4);
      for (int i = 0; i < 4 && i < rxq.size() && i < gq.size(); i++) begin
         chk("t3_rx",    rxq[i], 8'h10 + i);
         chk("t3_grant", gq[i],  1 << i);
      end
      chk("t3_count", bus.xfer_count, 4);

      // master 0 re-requests at once, master 2 keeps requesting
      rst = 1'b1; step(); rst = 1'b0;
      clear_logs();
      m_byte[0] = 8'h20; m_byte[2] = 8'h22; m_left[0] = 4; m_left[2] = 4;
      wait_done(400, "t4");
      chk("t4_g_n", gq.size(), 8);
      for (int i = 0; i < 8 && i < gq.size(); i++)
         chk("t4_alt", gq[i], (i % 2) ? 4'b0100 : 4'b0001);
      chk("t4_count", bus.xfer_count, 8);

      // master 1 drops req before the slave acks
      clear_logs();
      sl_wait = 3; m_byte[1] = 8'h5A; m_left[1] = 1; m_drop[1] = 1;
      wait_done(100, "t5");
      chk("t5_ackpulse", ack_seen[1], 1);
      chk("t5_rx_n",     rxq.size(),  1);
      if (rxq.size() > 0) chk("t5_rx", rxq[0], 8'h5A);
      chk("t5_count",    bus.xfer_count, 9);
      chk("t5_busy",     bus.busy, 0);

      // fill the counter to all-ones, then wrap on a transfer whose data_i is scrambled mid-REQ
      for (int k = 0; k < 20 && m_cnt != (1 << CW) - 1; k++) begin
         m_byte[k % NR] = DW'(8'h40 + k); m_left[k % NR] = 1;
         wait_done(100, "t6_fill");
      end
      chk("t6_full", bus.xfer_count, (1 << CW) - 1);
      clear_logs();
      sl_wait = 3; m_scram[3] = 1; m_byte[3] = 8'hC3; m_left[3] = 1;
      wait_done(100, "t6");
      m_scram[3] = 0;
      if (rxq.size() > 0) chk("t6_rx", rxq[rxq.size()-1], 8'hC3);
      chk("t6_wrap", bus.xfer_count, 0);

      // random traffic with occasional resets, model-checked every cycle
      rnd_data = 1; sl_lat = 3;
      for (int s = 0; s < 3000; s++) begin
         rst = ($urandom_range(199, 0) == 0);
         for (int m = 0; m < NR; m++)
            if (m_left[m] == 0 && $urandom_range(3, 0) == 0) begin
               m_left[m]  = $urandom_range(3, 1);
               m_drop[m]  = ($urandom_range(7, 0) == 0);
               m_scram[m] = 1'($urandom_range(1, 0));
            end
         step();
      end
      rst = 1'b0;
      for (int m = 0; m < NR; m++) m_left[m] = 0;
      wait_done(500, "rnd");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
